// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO, runtime parity and 1/2 stop bits.
// Optional line-break generation (break_req input, BREAK state) when UART_TX_BREAK_EN is defined.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int BAUD_DIV   = 868
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_en,
  input  logic                          parity_en,
  input  logic                          odd_parity,
  input  logic                          two_stop,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
`ifdef UART_TX_BREAK_EN
  input  logic                          break_req,
`endif
  output logic                          in_ready,
  output logic                          tx_out,
  output logic                          busy,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int BW    = $clog2(DATA_W + 4);

`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_BRK_END} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`endif

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_baud, w_baud_nxt;
  logic [BW-1:0]       r_bit, w_bit_nxt;
  logic                r_tx, w_tx_nxt;
  logic                w_pop, w_push, w_shift, w_bit_end, w_can_start;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [DATA_W-1:0]   r_shift, w_head;
  logic [AW-1:0]       r_wr, r_rd;
  logic [CW-1:0]       r_count, w_count_nxt;
  logic                r_full, r_empty;
  logic                r_par, r_par_en, r_two_stop;

  assign w_push      = in_valid && !r_full;
  assign w_head      = r_mem[r_rd];
  assign w_bit_end   = (r_baud == CNT_W'(BAUD_DIV - 1));
  assign w_can_start = tx_en && !r_empty;

  assign in_ready   = !r_full;
  assign tx_out     = r_tx;
  assign busy       = (r_state != S_IDLE);
  assign fifo_full  = r_full;
  assign fifo_empty = r_empty;
  assign fifo_count = r_count;

  always_comb begin
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // tx_nxt is the pin value for the cycle after the edge, so the pin is a pure flop
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = w_bit_end ? '0 : r_baud + CNT_W'(1);
    w_bit_nxt   = r_bit;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        w_bit_nxt  = '0;
        w_tx_nxt   = 1'b1;
`ifdef UART_TX_BREAK_EN
        if (break_req) begin
          w_state_nxt = S_BREAK;
          w_tx_nxt    = 1'b0;
        end else
`endif
        if (w_can_start) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit == BW'(DATA_W - 1)) begin
            w_bit_nxt = '0;
            if (r_par_en) begin
              w_state_nxt = S_PARITY;
              w_tx_nxt    = r_par;
            end else begin
              w_state_nxt = S_STOP;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_bit_nxt = r_bit + BW'(1);
            w_shift   = 1'b1;
            w_tx_nxt  = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_bit_nxt   = '0;
          w_tx_nxt    = 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_two_stop && r_bit == '0) begin
            w_bit_nxt = BW'(1);
          end else if (w_can_start) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
            w_bit_nxt   = '0;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_bit_nxt   = '0;
            w_tx_nxt    = 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      // r_bit saturates once the minimum break length has elapsed
      S_BREAK: begin
        if (w_bit_end) begin
          if (r_bit != BW'(DATA_W + 2)) begin
            w_bit_nxt = r_bit + BW'(1);
          end else if (!break_req) begin
            w_state_nxt = S_BRK_END;
            w_tx_nxt    = 1'b1;
          end
        end
      end
      S_BRK_END: begin
        if (w_bit_end) begin
          w_state_nxt = S_IDLE;
          w_bit_nxt   = '0;
          w_tx_nxt    = 1'b1;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_tx       <= 1'b1;
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_par_en   <= 1'b0;
      r_two_stop <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(FIFO_DEPTH));
      r_empty <= (w_count_nxt == '0);
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) begin
        r_rd       <= r_rd + AW'(1);
        r_par_en   <= parity_en;
        r_two_stop <= two_stop;
      end
    end
  end

  // Datapath storage carries no reset; pointers and counters define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= in_data;
    if (w_pop) begin
      r_shift <= w_head;
      r_par   <= (^w_head) ^ odd_parity;
    end else if (w_shift) begin
      r_shift <= r_shift >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table plus directed sequences,
// with a line-decoding scoreboard that checks every transmitted frame cycle by cycle.
module tb_uart_tx_fifo;

  localparam int DW = 8;
  localparam int FD = 4;
  localparam int BD = 4;

  logic           clk;
  logic           rst;
  logic           tx_en;
  logic           parity_en;
  logic           odd_parity;
  logic           two_stop;
  logic [DW-1:0]  in_data;
  logic           in_valid;
  logic           in_ready;
  logic           tx_out;
  logic           busy;
  logic           fifo_full;
  logic           fifo_empty;
  logic [2:0]     fifo_count;

  uart_tx_fifo #(.DATA_W(DW), .FIFO_DEPTH(FD), .BAUD_DIV(BD)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .parity_en  (parity_en),
    .odd_parity (odd_parity),
    .two_stop   (two_stop),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_out     (tx_out),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       od;
    logic       ts;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       od;
    logic       ts;
    int         exp_cyc;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[7];

  int   n_chk;
  int   n_fail;

  bit   m_active;
  bit   m_junk;
  int   m_k;
  int   m_len;
  int   m_err;
  int   m_frames;
  logic [7:0] m_cur;
  logic m_bits [0:11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Decodes the serial line after every edge and compares it against the expected frame
  task automatic mon_sample();
    exp_t e;
    int   idx;
    if (rst) begin
      m_active = 1'b0;
      m_junk   = 1'b0;
    end else begin
      if (m_junk && tx_out === 1'b1) m_junk = 1'b0;
      if (!m_active && !m_junk && tx_out === 1'b0) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_frame: start bit seen, required no frame (scoreboard empty)");
          m_junk = 1'b1;
        end else begin
          e = sb_q.pop_front();
          m_cur = e.data;
          m_bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) m_bits[1+i] = e.data[i];
          idx = 9;
          if (e.pe) begin
            m_bits[idx] = (^e.data) ^ e.od;
            idx++;
          end
          m_bits[idx] = 1'b1;
          idx++;
          if (e.ts) begin
            m_bits[idx] = 1'b1;
            idx++;
          end
          m_len    = idx;
          m_k      = 0;
          m_err    = 0;
          m_active = 1'b1;
        end
      end
      if (m_active) begin
        if (tx_out !== m_bits[m_k / BD] || busy !== 1'b1) m_err++;
        m_k++;
        if (m_k == m_len * BD) begin
          chk($sformatf("frame%0d_data%0h_bad_cycles", m_frames, m_cur), 32'(m_err), 32'd0);
          m_frames++;
          m_active = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mon_sample();
  endtask

  task automatic push(input logic [7:0] d);
    int t;
    t = 0;
    while (!in_ready && t < 400) begin
      tick();
      t++;
    end
    if (!in_ready) chk("push_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    sb_q.push_back('{d, parity_en, odd_parity, two_stop});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_idle(input int limit, output int bcyc, output int gaps);
    bit done;
    done = 1'b0;
    bcyc = 0;
    gaps = 0;
    for (int i = 0; i < limit && !done; i++) begin
      tick();
      if (busy) bcyc++;
      else if (!fifo_empty) gaps++;
      else done = 1'b1;
    end
    if (!done) chk("run_idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int b;
    int g;
    int f0;
    n_chk      = 0;
    n_fail     = 0;
    m_active   = 1'b0;
    m_junk     = 1'b0;
    m_frames   = 0;
    rst        = 1'b1;
    tx_en      = 1'b0;
    parity_en  = 1'b0;
    odd_parity = 1'b0;
    two_stop   = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 40};
    vecs[1] = '{8'h0F, 1'b1, 1'b1, 1'b0, 44};
    vecs[2] = '{8'h0F, 1'b1, 1'b0, 1'b0, 44};
    vecs[3] = '{8'h0F, 1'b1, 1'b0, 1'b1, 48};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 48};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b1, 44};
    vecs[6] = '{8'h81, 1'b1, 1'b0, 1'b0, 44};

    repeat (3) tick();
    chk("rst_tx_out",     32'(tx_out),     32'd1);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_fifo_empty", 32'(fifo_empty), 32'd1);
    chk("rst_fifo_full",  32'(fifo_full),  32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_in_ready",   32'(in_ready),   32'd1);
    rst = 1'b0;
    tick();

    // Single frames across data, parity and stop-bit settings
    for (int i = 0; i < 7; i++) begin
      tx_en      = 1'b1;
      parity_en  = vecs[i].pe;
      odd_parity = vecs[i].od;
      two_stop   = vecs[i].ts;
      push(vecs[i].data);
      tick();
      chk($sformatf("v%0d_empty_after_pop", i), 32'(fifo_empty), 32'd1);
      chk($sformatf("v%0d_start_bit", i), 32'(tx_out), 32'd0);
      run_idle(200, b, g);
      chk($sformatf("v%0d_busy_cycles", i), 32'(b + 1), 32'(vecs[i].exp_cyc));
      chk($sformatf("v%0d_sb_drained", i), 32'(sb_q.size()), 32'd0);
    end

    // Fill to full with tx disabled, then drain back-to-back
    tx_en = 1'b0; parity_en = 1'b0; odd_parity = 1'b0; two_stop = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h11 * (i + 1)));
    chk("full_in_ready",   32'(in_ready),   32'd0);
    chk("full_fifo_full",  32'(fifo_full),  32'd1);
    chk("full_fifo_count", 32'(fifo_count), 32'd4);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("full_push_rejected", 32'(fifo_count), 32'd4);
    f0    = m_frames;
    tx_en = 1'b1;
    run_idle(400, b, g);
    chk("b2b_busy_cycles", 32'(b), 32'd160);
    chk("b2b_idle_gaps",   32'(g), 32'd0);
    chk("b2b_frames",      32'(m_frames - f0), 32'd4);
    chk("b2b_fifo_empty",  32'(fifo_empty), 32'd1);
    chk("b2b_busy_end",    32'(busy), 32'd0);

    // Push coinciding with a frame-start pop
    tx_en = 1'b0;
    push(8'h51);
    push(8'h52);
    chk("simul_count_before", 32'(fifo_count), 32'd2);
    tx_en    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h53;
    sb_q.push_back('{8'h53, parity_en, odd_parity, two_stop});
    tick();
    in_valid = 1'b0;
    chk("simul_count_after", 32'(fifo_count), 32'd2);
    chk("simul_busy",        32'(busy), 32'd1);
    run_idle(600, b, g);
    chk("simul_busy_cycles", 32'(b + 1), 32'd120);
    chk("simul_sb_drained",  32'(sb_q.size()), 32'd0);

    // Reset during data bit 3 with three entries still queued
    tx_en = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h61 + i));
    tx_en = 1'b1;
    tick();
    chk("abort_count_after_pop", 32'(fifo_count), 32'd3);
    repeat (17) tick();
    rst = 1'b1;
    tick();
    chk("abort_tx_out",     32'(tx_out),     32'd1);
    chk("abort_busy",       32'(busy),       32'd0);
    chk("abort_fifo_count", 32'(fifo_count), 32'd0);
    chk("abort_in_ready",   32'(in_ready),   32'd1);
    chk("abort_fifo_empty", 32'(fifo_empty), 32'd1);
    sb_q.delete();
    rst = 1'b0;
    tick();
    f0 = m_frames;
    push(8'h3C);
    run_idle(200, b, g);
    chk("abort_recover_busy",   32'(b), 32'd40);
    chk("abort_recover_frames", 32'(m_frames - f0), 32'd1);

    // Config change mid-frame applies only to the next frame
    parity_en  = 1'b1;
    odd_parity = 1'b0;
    two_stop   = 1'b0;
    f0 = m_frames;
    push(8'hC3);
    tick();
    odd_parity = 1'b1;
    two_stop   = 1'b1;
    push(8'h3A);
    run_idle(400, b, g);
    chk("cfg_busy_cycles", 32'(b + 2), 32'd92);
    chk("cfg_idle_gaps",   32'(g), 32'd0);
    chk("cfg_frames",      32'(m_frames - f0), 32'd2);
    chk("cfg_sb_drained",  32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
